// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared constants and state type for the integer register file
package rv_pkg;

  localparam int XLEN     = 32;
  localparam int NREGS    = 32;
  localparam int REG_ZERO = 0;

  typedef enum logic {
    INIT,
    RUN
  } rf_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - busy bits, alloc handshake, busy counter and sticky writeback error
module rf_scoreboard #(
  parameter  int NREGS    = rv_pkg::NREGS,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             alloc_valid,
  input  logic [AW-1:0]    alloc_rd,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_rd,
  output logic [NREGS-1:0] busy,
  output logic             alloc_ready,
  output logic [AW:0]      busy_count,
  output logic             wb_err
);
  import rv_pkg::*;

  localparam logic [AW-1:0] ZADDR     = AW'(REG_ZERO);
  localparam bit            HARD_ZERO = (ZERO_REG != 0);
  localparam logic [AW:0]   ONE       = (AW+1)'(1);

  logic             wb_zero;
  logic             alloc_zero;
  logic             wb_match;
  logic             wb_hit;
  logic             alloc_take;
  logic             set_new;
  logic             clr_old;
  logic [NREGS-1:0] busy_d;

  always_comb begin
    wb_zero     = HARD_ZERO && (wb_rd == ZADDR);
    alloc_zero  = HARD_ZERO && (alloc_rd == ZADDR);
    wb_match    = wb_valid && (wb_rd == alloc_rd);
    alloc_ready = run && (!busy[alloc_rd] || wb_match);
    wb_hit      = run && wb_valid && !wb_zero;
    alloc_take  = alloc_valid && alloc_ready && !alloc_zero;
    set_new     = alloc_take && !busy[alloc_rd];
    // a release re-reserved in the same cycle leaves the bit set, so it is not a clear
    clr_old     = wb_hit && busy[wb_rd] && !(alloc_take && wb_match);
    busy_d      = busy;
    if (wb_hit)     busy_d[wb_rd]    = 1'b0;
    if (alloc_take) busy_d[alloc_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      busy_count <= '0;
      wb_err     <= 1'b0;
    end else begin
      busy <= busy_d;
      if (set_new && !clr_old)      busy_count <= busy_count + ONE;
      else if (clr_old && !set_new) busy_count <= busy_count - ONE;
      if (wb_hit && !busy[wb_rd])   wb_err <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - NRD-read/1-write register file with bypass, scoreboard and clear sequencer
module regfile_scoreboard #(
  parameter  int XLEN     = rv_pkg::XLEN,
  parameter  int NREGS    = rv_pkg::NREGS,
  parameter  int NRD      = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                alloc_valid,
  input  logic [AW-1:0]       alloc_rd,
  output logic                alloc_ready,
  input  logic                wb_valid,
  input  logic [AW-1:0]       wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  output logic                init_done,
  output logic [AW:0]         busy_count,
  output logic                wb_err
);
  import rv_pkg::*;

  localparam logic [AW-1:0] ZADDR     = AW'(REG_ZERO);
  localparam logic [AW-1:0] LAST      = AW'(NREGS - 1);
  localparam bit            HARD_ZERO = (ZERO_REG != 0);

  rf_state_e        state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] busy;
  logic             run;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == LAST) state_d = RUN;
    end
  end

  assign run       = (state_q == RUN);
  assign init_done = run;

  // storage has no reset; the INIT sweep is what clears it
  always_ff @(posedge clk) begin
    if (!run)
      mem[cnt_q] <= '0;
    else if (wb_valid && !(HARD_ZERO && wb_rd == ZADDR))
      mem[wb_rd] <= wb_data;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] addr;
    logic          zr;
    logic          byp;
    assign addr = ra[i*AW +: AW];
    assign zr   = HARD_ZERO && (addr == ZADDR);
    assign byp  = wb_valid && (wb_rd == addr);
    assign rdata[i*XLEN +: XLEN] = !run        ? '0      :
                                   (byp && !zr) ? wb_data :
                                   zr           ? '0      : mem[addr];
    assign rbusy[i] = run && busy[addr] && !byp;
  end

  rf_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .alloc_valid (alloc_valid),
    .alloc_rd    (alloc_rd),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .busy        (busy),
    .alloc_ready (alloc_ready),
    .busy_count  (busy_count),
    .wb_err      (wb_err)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - default and 16-entry/3-port/no-zero instances against a behavioural model
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  s_ra0 = '0, s_ra1 = '0, s_ra2 = '0;
  logic        alloc_valid = 1'b0;
  logic [4:0]  alloc_rd = '0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;

  logic [63:0] a_rdata;
  logic [1:0]  a_rbusy;
  logic        a_alloc_ready, a_init_done, a_wb_err;
  logic [5:0]  a_busy_count;
  logic [95:0] b_rdata;
  logic [2:0]  b_rbusy;
  logic        b_alloc_ready, b_init_done, b_wb_err;
  logic [4:0]  b_busy_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_scoreboard u_a (
    .clk(clk), .rst(rst), .ra({s_ra1, s_ra0}), .rdata(a_rdata), .rbusy(a_rbusy),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ready(a_alloc_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .init_done(a_init_done), .busy_count(a_busy_count), .wb_err(a_wb_err)
  );

  regfile_scoreboard #(.NREGS(16), .NRD(3), .ZERO_REG(0)) u_b (
    .clk(clk), .rst(rst), .ra({s_ra2[3:0], s_ra1[3:0], s_ra0[3:0]}), .rdata(b_rdata), .rbusy(b_rbusy),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd[3:0]), .alloc_ready(b_alloc_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd[3:0]), .wb_data(wb_data),
    .init_done(b_init_done), .busy_count(b_busy_count), .wb_err(b_wb_err)
  );

  // model state, index 0 = default instance, 1 = 16-entry instance without hard zero
  logic [31:0] mem_m  [2][32];
  bit          busy_m [2][32];
  bit          run_m  [2];
  bit          err_m  [2];
  int          icnt   [2];

  function automatic int nregs_of(input int d);
    return (d == 0) ? 32 : 16;
  endfunction

  function automatic int popc(input int d);
    int n = 0;
    for (int r = 0; r < 32; r++) if (busy_m[d][r]) n++;
    return n;
  endfunction

  function automatic logic [31:0] exp_rdata(input int d, input logic [4:0] addr);
    int a  = int'(addr) % nregs_of(d);
    int w  = int'(wb_rd) % nregs_of(d);
    bit zr = (d == 0) && (a == 0);
    if (!run_m[d]) return 32'h0;
    if (wb_valid && w == a && !zr) return wb_data;
    if (zr) return 32'h0;
    return mem_m[d][a];
  endfunction

  function automatic logic exp_rbusy(input int d, input logic [4:0] addr);
    int a = int'(addr) % nregs_of(d);
    int w = int'(wb_rd) % nregs_of(d);
    return run_m[d] && busy_m[d][a] && !(wb_valid && w == a);
  endfunction

  function automatic logic exp_ready(input int d);
    int al = int'(alloc_rd) % nregs_of(d);
    int w  = int'(wb_rd) % nregs_of(d);
    return run_m[d] && (!busy_m[d][al] || (wb_valid && w == al));
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        run_m[d] <= 1'b0;
        err_m[d] <= 1'b0;
        icnt[d]  <= 0;
        for (int r = 0; r < 32; r++) busy_m[d][r] <= 1'b0;
      end else if (!run_m[d]) begin
        mem_m[d][icnt[d]] <= 32'h0;
        icnt[d]           <= icnt[d] + 1;
        run_m[d]          <= (icnt[d] + 1 == nregs_of(d));
      end else begin
        int w, al;
        bit ok;
        w  = int'(wb_rd) % nregs_of(d);
        al = int'(alloc_rd) % nregs_of(d);
        ok = exp_ready(d);
        if (wb_valid && !(d == 0 && w == 0)) begin
          if (!busy_m[d][w]) err_m[d] <= 1'b1;
          mem_m[d][w]  <= wb_data;
          busy_m[d][w] <= 1'b0;
        end
        if (alloc_valid && ok && !(d == 0 && al == 0)) busy_m[d][al] <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("a_init_done",   32'(a_init_done),   32'(run_m[0]));
    chk("a_busy_count",  32'(a_busy_count),  popc(0));
    chk("a_wb_err",      32'(a_wb_err),      32'(err_m[0]));
    chk("a_alloc_ready", 32'(a_alloc_ready), 32'(exp_ready(0)));
    chk("a_rdata0", a_rdata[31:0],  exp_rdata(0, s_ra0));
    chk("a_rdata1", a_rdata[63:32], exp_rdata(0, s_ra1));
    chk("a_rbusy0", 32'(a_rbusy[0]), 32'(exp_rbusy(0, s_ra0)));
    chk("a_rbusy1", 32'(a_rbusy[1]), 32'(exp_rbusy(0, s_ra1)));
    chk("b_init_done",   32'(b_init_done),   32'(run_m[1]));
    chk("b_busy_count",  32'(b_busy_count),  popc(1));
    chk("b_wb_err",      32'(b_wb_err),      32'(err_m[1]));
    chk("b_alloc_ready", 32'(b_alloc_ready), 32'(exp_ready(1)));
    chk("b_rdata0", b_rdata[31:0],  exp_rdata(1, s_ra0));
    chk("b_rdata1", b_rdata[63:32], exp_rdata(1, s_ra1));
    chk("b_rdata2", b_rdata[95:64], exp_rdata(1, s_ra2));
    chk("b_rbusy0", 32'(b_rbusy[0]), 32'(exp_rbusy(1, s_ra0)));
    chk("b_rbusy1", 32'(b_rbusy[1]), 32'(exp_rbusy(1, s_ra1)));
    chk("b_rbusy2", 32'(b_rbusy[2]), 32'(exp_rbusy(1, s_ra2)));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alloc(input logic v, input logic [4:0] rd);
    alloc_valid = v;
    alloc_rd    = rd;
  endtask

  task automatic set_wb(input logic v, input logic [4:0] rd, input logic [31:0] data);
    wb_valid = v;
    wb_rd    = rd;
    wb_data  = data;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // clear sequence length: 16 cycles for the small instance, 32 for the default
    for (int k = 1; k <= 33; k++) begin
      tick();
      #1;
      if (k == 15) chk("t1_b_init_pre", 32'(b_init_done), 32'h0);
      if (k == 16) chk("t1_b_init",     32'(b_init_done), 32'h1);
      if (k == 31) chk("t1_a_init_pre", 32'(a_init_done), 32'h0);
      if (k == 32) chk("t1_a_init",     32'(a_init_done), 32'h1);
    end
    for (int k = 0; k < 32; k++) begin
      tick();
      s_ra0 = 5'(k); s_ra1 = 5'(31 - k); s_ra2 = 5'(k);
      #1 chk("t1_a_rdata", a_rdata[31:0], 32'h0);
    end
    chk("t1_a_busy_count", 32'(a_busy_count), 32'h0);

    tick(); set_alloc(1'b1, 5'd5);
    #1 chk("t2_ready", 32'(a_alloc_ready), 32'h1);
    tick(); set_alloc(1'b0, 5'd0); s_ra0 = 5'd5;
    #1 chk("t2_a_rbusy", 32'(a_rbusy[0]), 32'h1);
    chk("t2_b_rbusy", 32'(b_rbusy[0]), 32'h1);
    tick(); set_wb(1'b1, 5'd5, 32'hDEADBEEF);
    #1 chk("t2_bypass", a_rdata[31:0], 32'hDEADBEEF);
    chk("t2_rbusy_rel", 32'(a_rbusy[0]), 32'h0);
    tick(); set_wb(1'b0, 5'd0, 32'h0);
    #1 chk("t2_stored", a_rdata[31:0], 32'hDEADBEEF);
    chk("t2_b_stored", b_rdata[31:0], 32'hDEADBEEF);
    chk("t2_count", 32'(a_busy_count), 32'h0);

    tick(); set_alloc(1'b1, 5'd7);
    #1 chk("t3_first", 32'(a_alloc_ready), 32'h1);
    tick();
    #1 chk("t3_a_second", 32'(a_alloc_ready), 32'h0);
    chk("t3_b_second", 32'(b_alloc_ready), 32'h0);
    tick(); set_wb(1'b1, 5'd7, 32'h77);
    #1 chk("t3_wb_ready", 32'(a_alloc_ready), 32'h1);
    tick(); set_alloc(1'b0, 5'd0); set_wb(1'b0, 5'd0, 32'h0); s_ra0 = 5'd7;
    #1 chk("t3_a_count", 32'(a_busy_count), 32'h1);
    chk("t3_b_count", 32'(b_busy_count), 32'h1);
    chk("t3_still_busy", 32'(a_rbusy[0]), 32'h1);
    tick(); set_wb(1'b1, 5'd7, 32'h78);
    tick(); set_wb(1'b0, 5'd0, 32'h0);
    #1 chk("t3_released", 32'(a_busy_count), 32'h0);

    tick(); set_alloc(1'b1, 5'd0);
    tick(); set_alloc(1'b0, 5'd0); set_wb(1'b1, 5'd0, 32'h1234);
    tick(); set_wb(1'b0, 5'd0, 32'h0); s_ra0 = 5'd0; s_ra1 = 5'd0; s_ra2 = 5'd0;
    #1 chk("t4_a_x0_p0", a_rdata[31:0],  32'h0);
    chk("t4_a_x0_p1", a_rdata[63:32], 32'h0);
    chk("t4_a_rbusy", 32'(a_rbusy), 32'h0);
    chk("t4_a_err", 32'(a_wb_err), 32'h0);
    chk("t4_b_x0", b_rdata[95:64], 32'h1234);
    chk("t4_b_err", 32'(b_wb_err), 32'h0);

    tick(); set_wb(1'b1, 5'd9, 32'h55);
    tick(); set_wb(1'b0, 5'd0, 32'h0); s_ra0 = 5'd9;
    #1 chk("t5_data", a_rdata[31:0], 32'h55);
    chk("t5_a_err", 32'(a_wb_err), 32'h1);
    chk("t5_b_err", 32'(b_wb_err), 32'h1);
    repeat (5) tick();
    #1 chk("t5_sticky", 32'(a_wb_err), 32'h1);

    tick(); set_alloc(1'b1, 5'd3);
    tick(); set_alloc(1'b0, 5'd0); set_wb(1'b1, 5'd3, 32'hAAAA);
    tick(); set_wb(1'b0, 5'd0, 32'h0); set_alloc(1'b1, 5'd3);
    tick(); set_alloc(1'b1, 5'd4);
    tick(); set_alloc(1'b0, 5'd0); s_ra0 = 5'd3;
    #1 chk("t6_pre_count", 32'(a_busy_count), 32'h2);
    chk("t6_pre_data", a_rdata[31:0], 32'hAAAA);
    tick(); rst = 1'b1;
    #1 chk("t6_count", 32'(a_busy_count), 32'h0);
    chk("t6_init", 32'(a_init_done), 32'h0);
    chk("t6_err", 32'(b_wb_err), 32'h0);
    tick(); rst = 1'b0;
    repeat (33) tick();
    #1 chk("t6_a_cleared", a_rdata[31:0], 32'h0);
    chk("t6_b_cleared", b_rdata[31:0], 32'h0);
    chk("t6_a_done", 32'(a_init_done), 32'h1);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
